prio_arb: RTL and testbench

Parametrised, registered priority arbiter for N requesters: the sequential successor to the team's combinational priority encoder. Each arbitration picks one winner by fixed priority or round-robin, presents it as both index and one-hot, and holds it until the consumer acknowledges. It sits between a bank of request sources and a single shared resource.

---
 rtl/prio_pkg.sv | 12 +
 rtl/prio_pick.sv | 60 ++++++
 rtl/prio_arb.sv | 90 +++++++++
 tb/tb_prio_arb.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared types and constants for the priority arbiter
package prio_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } prio_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// rtl/prio_pick.sv - combinational winner selection, fixed priority or round-robin
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic           any,
  output logic [IDW-1:0] win_id,
  output logic [N-1:0]   win_onehot
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_masked;
  logic [IDW-1:0] rr_id;
  logic [IDW-1:0] fx_id;
  logic           found;

  assign dbl_req = {req, req};
  assign any     = |req;

  // Masking below ptr in the doubled vector makes the upper copy supply the wrap-around.
  always_comb begin
    dbl_masked = '0;
    for (int i = 0; i < 2 * N; i++) begin
      dbl_masked[i] = dbl_req[i] && (i >= int'(ptr));
    end
  end

  always_comb begin
    rr_id = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl_masked[i]) begin
        found = 1'b1;
        rr_id = IDW'(i % N);
      end
    end
  end

  always_comb begin
    fx_id = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fx_id = IDW'(i);
    end
  end

  assign win_id = (mode == MODE_RR) ? rr_id : fx_id;

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = any && (win_id == IDW'(i));
    end
  end

endmodule

// File: rtl/prio_arb.sv
// rtl/prio_arb.sv - registered priority arbiter holding each grant until acknowledged
module prio_arb
  import prio_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           mode,
  input  logic           gnt_ack,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   gnt_onehot
);

  prio_state_e    state_q, state_d;
  logic [IDW-1:0] rr_ptr, rr_ptr_d;
  logic           valid_d;
  logic [IDW-1:0] id_d;
  logic [N-1:0]   onehot_d;
  logic [IDW-1:0] ack_ptr;
  logic [IDW-1:0] pick_ptr;
  logic           pick_any;
  logic [IDW-1:0] pick_id;
  logic [N-1:0]   pick_onehot;

  assign ack_ptr  = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
  // Back-to-back re-arbitration must already see the pointer advanced past the grant being retired.
  assign pick_ptr = (state_q == ST_GRANT) ? ack_ptr : rr_ptr;

  prio_pick #(.N(N)) u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .mode       (mode),
    .any        (pick_any),
    .win_id     (pick_id),
    .win_onehot (pick_onehot)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = gnt_valid;
    id_d     = gnt_id;
    onehot_d = gnt_onehot;
    rr_ptr_d = rr_ptr;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_GRANT;
          valid_d  = 1'b1;
          id_d     = pick_id;
          onehot_d = pick_onehot;
        end
      end
      ST_GRANT: begin
        if (gnt_ack) begin
          rr_ptr_d = ack_ptr;
          if (pick_any) begin
            id_d     = pick_id;
            onehot_d = pick_onehot;
          end else begin
            state_d  = ST_IDLE;
            valid_d  = 1'b0;
            onehot_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      gnt_onehot <= '0;
      rr_ptr     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_valid  <= valid_d;
      gnt_id     <= id_d;
      gnt_onehot <= onehot_d;
      rr_ptr     <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_prio_arb.sv
// tb/tb_prio_arb.sv - self-checking bench for prio_arb with a reference model and scoreboard
module tb_prio_arb;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           mode = 1'b0;
  logic           gnt_ack = 1'b0;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   gnt_onehot;

  typedef struct {
    logic           valid;
    logic [IDW-1:0] id;
    logic [N-1:0]   onehot;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic           m_valid;
  logic [IDW-1:0] m_id;
  logic [IDW-1:0] m_ptr;

  always #5 clk = ~clk;

  prio_arb #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mode       (mode),
    .gnt_ack    (gnt_ack),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .gnt_onehot (gnt_onehot)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IDW-1:0] mpick(input logic [N-1:0] r, input logic [IDW-1:0] p,
                                           input logic m);
    if (m == 1'b0) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return IDW'(i);
    end else begin
      for (int k = 0; k < N; k++) if (r[(int'(p) + k) % N]) return IDW'((int'(p) + k) % N);
    end
    return '0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req = '0; mode = 1'b0; gnt_ack = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(gnt_valid), 0);
    check("rst_id", 32'(gnt_id), 0);
    check("rst_onehot", 32'(gnt_onehot), 0);
    m_valid = 1'b0; m_id = '0; m_ptr = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus, predict the registered result, compare after the edge.
  task automatic step(input logic [N-1:0] r, input logic m, input logic a, input string tag);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    req = r; mode = m; gnt_ack = a;
    if (!m_valid) begin
      if (r != '0) begin
        m_id = mpick(r, m_ptr, m);
        m_valid = 1'b1;
      end
    end else if (a) begin
      m_ptr = (m_id == IDW'(N - 1)) ? '0 : m_id + IDW'(1);
      if (r != '0) m_id = mpick(r, m_ptr, m);
      else m_valid = 1'b0;
    end
    e.valid  = m_valid;
    e.id     = m_id;
    e.onehot = m_valid ? (N'(1) << m_id) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check({tag, "_valid"}, 32'(gnt_valid), 32'(got_e.valid));
    check({tag, "_id"}, 32'(gnt_id), 32'(got_e.id));
    check({tag, "_onehot"}, 32'(gnt_onehot), 32'(got_e.onehot));
  endtask

  initial begin
    logic [IDW-1:0] rr_seq [4];
    rr_seq = '{2'd1, 2'd2, 2'd3, 2'd0};

    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b0, "idle");
    check("idle_const", 32'(gnt_onehot), 0);

    step(4'b0110, 1'b0, 1'b0, "fix1");
    check("fix1_const", 32'(gnt_onehot), 32'h4);
    step(4'b0011, 1'b0, 1'b1, "fix2");
    check("fix2_const", 32'(gnt_id), 1);

    do_reset();
    step(4'b1111, 1'b1, 1'b0, "rr0");
    check("rr0_const", 32'(gnt_id), 0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 1'b1, 1'b1, "rr");
      check("rr_seq_const", 32'(gnt_id), 32'(rr_seq[i]));
      check("rr_valid_const", 32'(gnt_valid), 1);
    end

    do_reset();
    step(4'b1000, 1'b1, 1'b0, "hold0");
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b1, 1'b0, "hold");
      check("hold_id_const", 32'(gnt_id), 3);
    end
    step(4'b0000, 1'b1, 1'b1, "hold_ack");
    check("hold_ack_valid_const", 32'(gnt_valid), 0);
    step(4'b1001, 1'b1, 1'b0, "hold_next");
    check("hold_next_const", 32'(gnt_id), 0);

    do_reset();
    step(4'b0010, 1'b1, 1'b0, "msw0");
    step(4'b1010, 1'b0, 1'b1, "msw1");
    check("msw_const", 32'(gnt_id), 3);

    do_reset();
    step(4'b0100, 1'b0, 1'b0, "ar0");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(gnt_valid), 0);
    check("ar_id", 32'(gnt_id), 0);
    check("ar_onehot", 32'(gnt_onehot), 0);
    m_valid = 1'b0; m_id = '0; m_ptr = '0;
    sb.delete();
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 1'b0, "ar1");
    check("ar1_const", 32'(gnt_id), 0);

    for (int i = 0; i < 80; i++) begin
      step(N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
